dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter/sequencer in front of the 256 KiB byte-addressed data memory.
- Shares the memory between the instruction-fetch port (I, read-only) and the load/store port (D, read/write) using round-robin arbitration.
- Drives the memory's visit/addr/data/write_enable strobe and detects completion from the memory's toggle flag (vivi).
- Rejects misaligned or out-of-range accesses locally and returns data with a done pulse.

Parameters:
- MEM_BYTES, 262144, memory size in bytes; legal word addresses are 0..MEM_BYTES-4.
- TIMEOUT, 15, WAIT-state cycles without a vivi toggle before the access is aborted with an error.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset0  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request, level; held until i_ack.
- i_addr  in  32  fetch byte address.
- i_ack  out  1  one-cycle grant; I request latched.
- i_done  out  1  one-cycle completion for the I port.
- d_req  in  1  load/store request, level; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  load/store byte address.
- d_wdata  in  32  store data, big-endian word.
- d_ack  out  1  one-cycle grant; D request latched.
- d_done  out  1  one-cycle completion for the D port.
- rdata  out  32  read result; valid while i_done or d_done is high.
- err  out  1  error flag; valid with done (misaligned, out of range, or timeout).
- mem_visit  out  1  memory access strobe; memory acts on negedge while high.
- mem_addr  out  32  memory address.
- mem_data  out  32  memory write data.
- mem_we  out  1  memory write enable.
- mem_outp  in  32  memory read data.
- mem_valid  in  1  memory alignment-valid flag.
- mem_vivi  in  1  memory completion toggle; flips once per serviced access.

Behaviour:
- All outputs are registered.
- Reset (reset0=0, async): state=IDLE; all acks, dones, err and mem_visit/mem_we = 0; mem_addr, mem_data and rdata = 0; last_grant=D, so I wins the first tie; timeout counter = 0.
- Reset mid-access abandons the access; no done is produced.
- States: IDLE, ISSUE, WAIT.
- IDLE, edge N, with any request:
  - Arbitration: only one req -> grant it; both -> grant the port that is not last_grant; update last_grant.
  - Assert the granted ack for one cycle; latch addr, we (I port: we=0) and wdata; snapshot mem_vivi into vivi_ref.
  - Legality check: addr[1:0]!=0 or addr>MEM_BYTES-4 is illegal.
    - Illegal: no memory visit; at edge N+1 the port's done=1, err=1, rdata=0; return to IDLE.
    - Legal: mem_visit=1, mem_addr=addr, mem_we=we, mem_data=wdata; go to ISSUE.
- ISSUE, edge N+1: mem_visit=0, mem_we=0; timeout counter=0; go to WAIT. Memory performs the access on the negedge between N and N+1; mem_visit is high for exactly one cycle, so there is exactly one memory access per request.
- WAIT, each edge:
  - If mem_vivi != vivi_ref: rdata = mem_outp (loads) or 0 (stores); err = ~mem_valid; pulse the granted port's done; go to IDLE.
  - Else increment the counter. When the counter reaches TIMEOUT: done=1, err=1, rdata=0; go to IDLE.
- Nominal latency: ack at edge N, done at edge N+2. The next grant is at the earliest at edge N+3 (one idle cycle between accesses).
- Requesters deassert req the cycle after ack. A req still high at the edge after done is a new request.
- Address and data inputs are ignored except at grant.
- last_grant updates only on grant, including illegal-address grants.
- Simultaneous requests in IDLE are always resolved by round-robin. A port never waits more than one other access.

Test Plan:
- Single store then load: D store addr=0x100, wdata=0xDEADBEEF -> d_ack at edge N, mem_visit high 1 cycle, d_done at N+2 with err=0; then D load addr=0x100 -> rdata=0xDEADBEEF, err=0.
- Simultaneous requests from reset: i_req and d_req both high -> I granted first, D granted at the earliest legal edge after i_done; repeated contention alternates I, D, I, D.
- Misaligned D store addr=0x102 -> no mem_visit pulse, d_done one cycle after d_ack with err=1, rdata=0; a following load from 0x100 still returns the prior contents.
- Out-of-range I fetch addr=0x40000 -> i_done with err=1, mem_visit stays 0.
- Memory stub never toggles vivi -> d_done with err=1 exactly TIMEOUT+1 cycles after ISSUE exits; the arbiter then accepts the next request.
- reset0 pulsed low during WAIT -> all outputs 0 immediately (async), no done pulse; after release, an I fetch from 0x0 completes normally, proving last_grant reset to D.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arbiter_if : fetch/load-store request ports and memory strobe bus    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface dmem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_visit;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic [31:0] mem_outp;
    logic        mem_valid;
    logic        mem_vivi;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  mem_outp, mem_valid, mem_vivi,
        output i_ack, i_done, d_ack, d_done, rdata, err,
        output mem_visit, mem_addr, mem_data, mem_we
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output mem_outp, mem_valid, mem_vivi,
        input  i_ack, i_done, d_ack, d_done, rdata, err,
        input  mem_visit, mem_addr, mem_data, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arbiter : round-robin fetch/load-store sequencer for the data memory |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module dmem_arbiter #(
    parameter int MEM_BYTES = 262144,
    parameter int TIMEOUT   = 15
) (
    input  logic           clock,
    input  logic           reset0,
    dmem_arbiter_if.slave  bus
);
    localparam logic [31:0]   MAX_ADDR  = 32'(MEM_BYTES - 4);
    localparam int            CW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_d_q, last_d_d;
    logic          gnt_d_q, gnt_d_d;
    logic          we_q, we_d;
    logic          illegal_q, illegal_d;
    logic          vivi_ref_q, vivi_ref_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          mem_visit_q, mem_visit_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_data_q, mem_data_d;
    logic          mem_we_q, mem_we_d;

    logic          w_pick_d;
    logic [31:0]   w_addr;
    logic          w_we;
    logic [31:0]   w_wdata;
    logic          w_legal;
    logic          w_fin;
    logic          w_fin_err;
    logic [31:0]   w_fin_rdata;

    // On a tie the port that did not win last time is chosen.
    assign w_pick_d = bus.d_req & (~bus.i_req | ~last_d_q);
    assign w_addr   = w_pick_d ? bus.d_addr : bus.i_addr;
    assign w_we     = w_pick_d & bus.d_we;
    assign w_wdata  = w_pick_d ? bus.d_wdata : 32'h0;
    assign w_legal  = (w_addr[1:0] == 2'b00) && (w_addr <= MAX_ADDR);

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        gnt_d_d     = gnt_d_q;
        we_d        = we_q;
        illegal_d   = illegal_q;
        vivi_ref_d  = vivi_ref_q;
        cnt_d       = cnt_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_visit_d = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        w_fin       = 1'b0;
        w_fin_err   = 1'b0;
        w_fin_rdata = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    last_d_d   = w_pick_d;
                    gnt_d_d    = w_pick_d;
                    i_ack_d    = ~w_pick_d;
                    d_ack_d    = w_pick_d;
                    we_d       = w_we;
                    vivi_ref_d = bus.mem_vivi;
                    illegal_d  = ~w_legal;
                    if (w_legal) begin
                        mem_visit_d = 1'b1;
                        mem_addr_d  = w_addr;
                        mem_we_d    = w_we;
                        mem_data_d  = w_wdata;
                    end
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                cnt_d = '0;
                // Rejected accesses complete here without touching memory.
                if (illegal_q) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.mem_vivi != vivi_ref_q) begin
                    w_fin       = 1'b1;
                    w_fin_err   = ~bus.mem_valid;
                    w_fin_rdata = we_q ? 32'h0 : bus.mem_outp;
                end else if (cnt_q == C_TIMEOUT) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (w_fin) begin
            i_done_d = ~gnt_d_q;
            d_done_d = gnt_d_q;
            err_d    = w_fin_err;
            rdata_d  = w_fin_rdata;
            state_d  = S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset0) begin
        if (!reset0) begin
            state_q     <= S_IDLE;
            last_d_q    <= 1'b1;
            gnt_d_q     <= 1'b0;
            we_q        <= 1'b0;
            illegal_q   <= 1'b0;
            vivi_ref_q  <= 1'b0;
            cnt_q       <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            mem_visit_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_data_q  <= 32'h0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            gnt_d_q     <= gnt_d_d;
            we_q        <= we_d;
            illegal_q   <= illegal_d;
            vivi_ref_q  <= vivi_ref_d;
            cnt_q       <= cnt_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mem_visit_q <= mem_visit_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
    assign bus.mem_visit = mem_visit_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.mem_we    = mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_arbiter : directed and random stimulus against a transaction model|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_dmem_arbiter;
    localparam int MEM_BYTES = 262144;
    localparam int TIMEOUT   = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clock  (clk),
        .reset0 (rst_n),
        .bus    (bus)
    );

    // requester drives
    logic        t_i_req   = 1'b0;
    logic [31:0] t_i_addr  = 32'h0;
    logic        t_d_req   = 1'b0;
    logic        t_d_we    = 1'b0;
    logic [31:0] t_d_addr  = 32'h0;
    logic [31:0] t_d_wdata = 32'h0;
    assign bus.i_req   = t_i_req;
    assign bus.i_addr  = t_i_addr;
    assign bus.d_req   = t_d_req;
    assign bus.d_we    = t_d_we;
    assign bus.d_addr  = t_d_addr;
    assign bus.d_wdata = t_d_wdata;

    // memory stub: acts on negedge while visit is high, flips vivi unless stalled
    logic [31:0] s_outp  = 32'h0;
    logic        s_valid = 1'b0;
    logic        s_vivi  = 1'b0;
    logic        stall   = 1'b0;
    int          visits  = 0;
    int          s_idx;
    logic [31:0] smem [int];
    assign bus.mem_outp  = s_outp;
    assign bus.mem_valid = s_valid;
    assign bus.mem_vivi  = s_vivi;

    always @(negedge clk) begin
        if (bus.mem_visit === 1'b1) begin
            visits++;
            if (!stall) begin
                s_idx = int'(bus.mem_addr[17:2]);
                if (bus.mem_we) smem[s_idx] = bus.mem_data;
                else            s_outp = smem.exists(s_idx) ? smem[s_idx] : 32'h0;
                s_valid = (bus.mem_addr[1:0] == 2'b00);
                s_vivi  = ~s_vivi;
            end
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic to_fail(input string nm);
        checks++;
        fails++;
        $display("FAIL %s: wait bound expired, got no event, required one at %0t", nm, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [31:0] refmem [int];
    int          cyc     = 0;
    int          free_at = 0;
    bit          m_last_d = 1'b1;
    bit          pend     = 1'b0;
    int          pend_cyc;
    bit          pend_d;
    bit          pend_err;
    logic [31:0] pend_rd;
    logic [31:0] m_addr, m_data, m_rd;
    logic        m_err;
    logic        e_iack, e_dack, e_idone, e_ddone, e_visit, e_we;
    bit          g_d, g_we, g_legal;
    logic [31:0] g_addr, g_wd;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int k;
        k = int'(a[17:2]);
        return refmem.exists(k) ? refmem[k] : 32'h0;
    endfunction

    initial begin
        m_addr = 0; m_data = 0; m_rd = 0; m_err = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            {e_iack, e_dack, e_idone, e_ddone, e_visit, e_we} = '0;
            if (!rst_n) begin
                pend = 0; free_at = 0; m_last_d = 1'b1;
                m_addr = 0; m_data = 0; m_rd = 0; m_err = 0;
                chk("rst_mem_addr", bus.mem_addr, 32'h0);
                chk("rst_mem_data", bus.mem_data, 32'h0);
                chk("rst_rdata",    bus.rdata,    32'h0);
                chk("rst_err",      bus.err,      32'h0);
            end else if (pend && cyc == pend_cyc) begin
                e_idone = ~pend_d;
                e_ddone = pend_d;
                m_err   = pend_err;
                m_rd    = pend_rd;
                pend    = 0;
                free_at = cyc + 1;
            end else if (!pend && cyc >= free_at && (t_i_req || t_d_req)) begin
                g_d     = t_d_req && (!t_i_req || !m_last_d);
                m_last_d = g_d;
                g_addr  = g_d ? t_d_addr : t_i_addr;
                g_we    = g_d && t_d_we;
                g_wd    = g_d ? t_d_wdata : 32'h0;
                g_legal = (g_addr % 4 == 0) && (g_addr <= MEM_BYTES - 4);
                e_iack  = ~g_d;
                e_dack  = g_d;
                pend    = 1;
                pend_d  = g_d;
                if (!g_legal) begin
                    pend_cyc = cyc + 1; pend_err = 1; pend_rd = 0;
                end else begin
                    e_visit = 1; e_we = g_we; m_addr = g_addr; m_data = g_wd;
                    if (stall) begin
                        pend_cyc = cyc + 2 + TIMEOUT; pend_err = 1; pend_rd = 0;
                    end else begin
                        pend_cyc = cyc + 2; pend_err = 0;
                        pend_rd  = g_we ? 32'h0 : ref_rd(g_addr);
                        if (g_we) refmem[int'(g_addr[17:2])] = g_wd;
                    end
                end
            end
            chk("i_ack",     bus.i_ack,     e_iack);
            chk("d_ack",     bus.d_ack,     e_dack);
            chk("i_done",    bus.i_done,    e_idone);
            chk("d_done",    bus.d_done,    e_ddone);
            chk("mem_visit", bus.mem_visit, e_visit);
            chk("mem_we",    bus.mem_we,    e_we);
            if (e_visit) begin
                chk("mem_addr", bus.mem_addr, m_addr);
                chk("mem_data", bus.mem_data, m_data);
            end
            if (e_idone || e_ddone) begin
                chk("err",   bus.err,   m_err);
                chk("rdata", bus.rdata, m_rd);
            end
        end
    end

    // ---------------- stimulus ----------------
    int order [$];

    // Called and returns just after a negedge; lat = cycles from ack edge to done edge.
    task automatic issue(input bit pd, input bit we, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic e);
        int n;
        lat = -1; rd = 32'hx; e = 1'bx;
        if (pd) begin t_d_req = 1; t_d_we = we; t_d_addr = a; t_d_wdata = wd; end
        else    begin t_i_req = 1; t_i_addr = a; end
        n = 0;
        forever begin
            @(posedge clk); #1;
            if (pd ? bus.d_ack : bus.i_ack) break;
            n++;
            if (n > 40) begin to_fail("ack_wait"); break; end
        end
        @(negedge clk);
        if (pd) begin t_d_req = 0; t_d_addr = $urandom; t_d_wdata = $urandom; end
        else    begin t_i_req = 0; t_i_addr = $urandom; end
        n = 0;
        forever begin
            @(posedge clk); #1;
            n++;
            if (pd ? bus.d_done : bus.i_done) begin lat = n; rd = bus.rdata; e = bus.err; break; end
            if (n > 40) begin to_fail("done_wait"); break; end
        end
        @(negedge clk);
    endtask

    task automatic contend(input int rounds);
        int n, dones, a0;
        bit di, dd;
        for (int r = 0; r < rounds; r++) begin
            t_i_req = 1; t_i_addr = 32'h10;
            t_d_req = 1; t_d_we = 0; t_d_addr = 32'h20; t_d_wdata = 32'h0;
            n = 0; dones = 0; a0 = -1;
            forever begin
                @(posedge clk); #1;
                n++; di = 0; dd = 0;
                if (bus.i_ack) begin
                    order.push_back(0); di = 1;
                    if (a0 < 0) a0 = n; else chk("contend_gap", n - a0, 3);
                end
                if (bus.d_ack) begin
                    order.push_back(1); dd = 1;
                    if (a0 < 0) a0 = n; else chk("contend_gap", n - a0, 3);
                end
                if (bus.i_done) dones++;
                if (bus.d_done) dones++;
                @(negedge clk);
                if (di) t_i_req = 0;
                if (dd) t_d_req = 0;
                if (dones >= 2) break;
                if (n > 60) begin to_fail("contend"); t_i_req = 0; t_d_req = 0; break; end
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0)      return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        else if (r == 1) return 32'(MEM_BYTES) + (32'($urandom_range(0, 15)) << 2);
        else if (r == 2) return 32'(MEM_BYTES - 4);
        else             return 32'h400 + (32'($urandom_range(0, 31)) << 2);
    endfunction

    task automatic rand_phase(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (bus.i_ack) t_i_req = 0;
            else if (!t_i_req && $urandom_range(0, 3) == 0) begin
                t_i_req = 1; t_i_addr = rand_addr();
            end
            if (bus.d_ack) t_d_req = 0;
            else if (!t_d_req && $urandom_range(0, 2) == 0) begin
                t_d_req = 1; t_d_we = 1'($urandom_range(0, 1));
                t_d_addr = rand_addr(); t_d_wdata = $urandom;
            end
        end
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.i_ack) t_i_req = 0;
            if (bus.d_ack) t_d_req = 0;
            if (!t_i_req && !t_d_req) break;
        end
        repeat (TIMEOUT + 5) @(negedge clk);
    endtask

    initial begin
        int          lat, v0, n;
        logic [31:0] rd;
        logic        e;

        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("reset_i_ack",     bus.i_ack,     0);
        chk("reset_d_done",    bus.d_done,    0);
        chk("reset_mem_visit", bus.mem_visit, 0);
        chk("reset_mem_addr",  bus.mem_addr,  0);
        chk("reset_rdata",     bus.rdata,     0);
        rst_n = 1;
        @(negedge clk);

        order.delete();
        contend(2);
        chk("order_len", order.size(), 4);
        for (int k = 0; k < order.size(); k++) chk("order", order[k], k % 2);

        v0 = visits;
        issue(1, 1, 32'h100, 32'hDEADBEEF, lat, rd, e);
        chk("store_lat", lat, 2);
        chk("store_err", e, 0);
        chk("store_visits", visits - v0, 1);
        issue(1, 0, 32'h100, 32'h0, lat, rd, e);
        chk("load_lat", lat, 2);
        chk("load_rdata", rd, 32'hDEADBEEF);
        chk("load_err", e, 0);

        v0 = visits;
        issue(1, 1, 32'h102, 32'h12345678, lat, rd, e);
        chk("misalign_lat", lat, 1);
        chk("misalign_err", e, 1);
        chk("misalign_rdata", rd, 0);
        chk("misalign_visits", visits - v0, 0);
        issue(1, 0, 32'h100, 32'h0, lat, rd, e);
        chk("after_misalign_rdata", rd, 32'hDEADBEEF);

        v0 = visits;
        issue(0, 0, 32'h40000, 32'h0, lat, rd, e);
        chk("oor_lat", lat, 1);
        chk("oor_err", e, 1);
        chk("oor_visits", visits - v0, 0);
        issue(0, 0, 32'h3FFFC, 32'h0, lat, rd, e);
        chk("top_word_lat", lat, 2);
        chk("top_word_err", e, 0);

        stall = 1;
        issue(1, 0, 32'h100, 32'h0, lat, rd, e);
        chk("timeout_lat", lat, TIMEOUT + 2);
        chk("timeout_err", e, 1);
        chk("timeout_rdata", rd, 0);
        stall = 0;
        issue(1, 0, 32'h100, 32'h0, lat, rd, e);
        chk("post_timeout_rdata", rd, 32'hDEADBEEF);
        chk("post_timeout_lat", lat, 2);

        // I access left hanging in WAIT, then reset (last grant was I before reset)
        stall = 1;
        t_i_req = 1; t_i_addr = 32'h300;
        n = 0;
        forever begin
            @(posedge clk); #1;
            if (bus.i_ack) break;
            n++;
            if (n > 40) begin to_fail("rst_test_ack"); break; end
        end
        @(negedge clk);
        t_i_req = 0;
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("pre_rst_mem_addr", bus.mem_addr, 32'h300);
        rst_n = 0;
        #1;
        chk("async_rst_mem_addr", bus.mem_addr, 0);
        chk("async_rst_rdata",    bus.rdata,    0);
        chk("async_rst_i_done",   bus.i_done,   0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_no_done", bus.i_done, 0);
        end
        @(negedge clk);
        rst_n = 1;
        stall = 0;

        order.delete();
        contend(1);
        chk("post_rst_first", order.size() > 0 ? order[0] : -1, 0);
        issue(0, 0, 32'h0, 32'h0, lat, rd, e);
        chk("post_rst_fetch_lat", lat, 2);
        chk("post_rst_fetch_err", e, 0);
        chk("post_rst_fetch_rdata", rd, 0);

        rand_phase(1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
